// File: rtl/pcpu_pkg.sv
// Shared fetch-stage constants and saturating-counter helpers.
// Counters are carried at 4 bits in the helpers; callers slice to their own width.
package pcpu_pkg;

  localparam logic [31:0] PC_INITIAL = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Weakly-taken start value, indexed by counter width (1..4).
  localparam logic [3:0] WEAK_TAKEN [1:4] = '{4'd1, 4'd2, 4'd4, 4'd8};

  function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input int bits);
    logic [3:0] maxVal;
    maxVal = 4'((1 << bits) - 1);
    return (ctr == maxVal) ? ctr : ctr + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] ctr, input int bits);
    logic [3:0] unusedBits;
    unusedBits = 4'(bits);
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/pcpu_btb.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, one registered update from EX.
// Lookup sees pre-edge contents when it shares an index with the update.
module pcpu_btb
  import pcpu_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookupPc,
  output logic        lookupHit,
  output logic        lookupTaken,
  output logic [31:0] lookupTarget,
  input  logic        updValid,
  input  logic [31:0] updPc,
  input  logic        updIsBranch,
  input  logic        updTaken,
  input  logic [31:0] updTarget,
  input  logic        updPredTaken
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [3:0] WEAK4 = WEAK_TAKEN[CTR_BITS];
  localparam logic [CTR_BITS-1:0] WEAK = WEAK4[CTR_BITS-1:0];

  logic                valid   [ENTRIES];
  logic [TAG_W-1:0]    tags    [ENTRIES];
  logic [31:0]         targets [ENTRIES];
  logic [CTR_BITS-1:0] ctrs    [ENTRIES];

  logic [IDX-1:0]      lIdx, uIdx;
  logic [TAG_W-1:0]    lTag, uTag;
  logic                uHit;
  logic [3:0]          ctrInc, ctrDec;
  logic [CTR_BITS-1:0] nextCtr;
  logic                unusedPcBits;

  assign lIdx = lookupPc[IDX+1:2];
  assign lTag = lookupPc[31:IDX+2];
  assign uIdx = updPc[IDX+1:2];
  assign uTag = updPc[31:IDX+2];
  assign unusedPcBits = &{1'b0, lookupPc[1:0], updPc[1:0]};

  assign lookupHit    = valid[lIdx] && (tags[lIdx] == lTag);
  assign lookupTaken  = lookupHit && ctrs[lIdx][CTR_BITS-1];
  assign lookupTarget = targets[lIdx];

  assign uHit = valid[uIdx] && (tags[uIdx] == uTag);

  always_comb begin
    ctrInc  = sat_inc(4'(ctrs[uIdx]), CTR_BITS);
    ctrDec  = sat_dec(4'(ctrs[uIdx]), CTR_BITS);
    nextCtr = updTaken ? ctrInc[CTR_BITS-1:0] : ctrDec[CTR_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctrs[i]  <= '0;
      end
    end else if (updValid) begin
      if (updIsBranch) begin
        if (uHit) begin
          ctrs[uIdx] <= nextCtr;
        end else if (updTaken) begin
          valid[uIdx] <= 1'b1;
          ctrs[uIdx]  <= WEAK;
        end
      end else if (updPredTaken && uHit) begin
        // A non-branch predicted taken is an alias; drop the stale entry.
        valid[uIdx] <= 1'b0;
      end
    end
  end

  // Tag and target only change on taken branches; valid gates their meaning.
  always_ff @(posedge clk) begin
    if (!rst && updValid && updIsBranch && updTaken) begin
      tags[uIdx]    <= uTag;
      targets[uIdx] <= updTarget;
    end
  end

endmodule

// File: rtl/pcpu_fetch_predict.sv
// IF stage: PC register, BTB-steered next PC, EX mispredict redirect and perf counters.
// Prediction steers the next PC in 1 cycle; stall holds the PC unless EX redirects.
module pcpu_fetch_predict
  import pcpu_pkg::*;
#(
  parameter logic [31:0] PC_INIT     = PC_INITIAL,
  parameter int          BTB_ENTRIES = 16,
  parameter int          CTR_BITS    = 2,
  parameter int          PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [31:0]       addrInst,
  output logic              if_predTaken,
  output logic [31:0]       if_predTarget,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic              ex_isBranch,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  input  logic              ex_predTaken,
  input  logic [31:0]       ex_predTarget,
  output logic              redirect,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredict
);

  logic [31:0] pc, pcPlus4, nextPc, correctPc;
  logic        btbHit, btbTaken, mispredict;
  logic [31:0] btbTarget;

  pcpu_btb #(
    .ENTRIES (BTB_ENTRIES),
    .CTR_BITS(CTR_BITS)
  ) btb (
    .clk         (clk),
    .rst         (rst),
    .lookupPc    (pc),
    .lookupHit   (btbHit),
    .lookupTaken (btbTaken),
    .lookupTarget(btbTarget),
    .updValid    (ex_valid),
    .updPc       (ex_pc),
    .updIsBranch (ex_isBranch),
    .updTaken    (ex_taken),
    .updTarget   (ex_target),
    .updPredTaken(ex_predTaken)
  );

  assign addrInst      = pc;
  assign pcPlus4       = pc + INST_BYTES;
  assign if_predTaken  = btbTaken;
  assign if_predTarget = btbHit ? btbTarget : pcPlus4;

  assign mispredict = ex_valid && (ex_isBranch
                      ? ((ex_taken != ex_predTaken) || (ex_taken && (ex_target != ex_predTarget)))
                      : ex_predTaken);
  assign redirect   = mispredict;
  assign correctPc  = (ex_isBranch && ex_taken) ? ex_target : ex_pc + INST_BYTES;

  // EX correction beats a hazard stall: the stalled instruction is being flushed anyway.
  always_comb begin
    nextPc = pcPlus4;
    if (mispredict)        nextPc = correctPc;
    else if (stall)        nextPc = pc;
    else if (if_predTaken) nextPc = if_predTarget;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= PC_INIT;
      perf_branches   <= '0;
      perf_mispredict <= '0;
    end else begin
      pc <= nextPc;
      if (ex_valid && ex_isBranch && (perf_branches != '1))
        perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict && (perf_mispredict != '1))
        perf_mispredict <= perf_mispredict + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pcpu_fetch_predict.sv
// Bench for pcpu_fetch_predict: directed scenarios with literal expectations, then random EX
// traffic checked every cycle against a table-based model of the fetch/predict rules.
module tb_pcpu_fetch_predict;

  localparam int          ENT  = 16;
  localparam int          CB   = 2;
  localparam int          PW   = 6;
  localparam logic [31:0] PCI  = 32'h0000_0000;
  localparam int          PMAX = (1 << PW) - 1;
  localparam int          CMAX = (1 << CB) - 1;
  localparam int          CTHR = 1 << (CB - 1);

  logic          clk = 1'b0;
  logic          rst, stall, ex_valid, ex_isBranch, ex_taken, ex_predTaken;
  logic [31:0]   ex_pc, ex_target, ex_predTarget;
  logic [31:0]   addrInst, if_predTarget;
  logic          if_predTaken, redirect;
  logic [PW-1:0] perf_branches, perf_mispredict;

  pcpu_fetch_predict #(
    .PC_INIT(PCI), .BTB_ENTRIES(ENT), .CTR_BITS(CB), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .addrInst(addrInst), .if_predTaken(if_predTaken), .if_predTarget(if_predTarget),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_isBranch(ex_isBranch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_predTaken(ex_predTaken), .ex_predTarget(ex_predTarget),
    .redirect(redirect), .perf_branches(perf_branches), .perf_mispredict(perf_mispredict)
  );

  always #5 clk = ~clk;

  // Model state: one record per BTB slot, plus PC and event counts.
  bit          mValid [ENT];
  logic [31:0] mTag   [ENT];
  logic [31:0] mTgt   [ENT];
  int          mCtr   [ENT];
  logic [31:0] mPc;
  int          mBr, mMis;
  bit          mLive = 1'b0;
  int          total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic int idxOf(input logic [31:0] a);
    return int'((a / 4) % ENT);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a / (4 * ENT);
  endfunction

  function automatic bit mHit(input logic [31:0] a);
    return mValid[idxOf(a)] && (mTag[idxOf(a)] == tagOf(a));
  endfunction

  task automatic cycle(input bit r, input bit s, input bit v, input logic [31:0] epc,
                       input bit br, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
    bit          hit, pT, mis;
    logic [31:0] pTg, corr;
    int          i;
    @(negedge clk);
    rst = r; stall = s; ex_valid = v; ex_pc = epc; ex_isBranch = br; ex_taken = tk;
    ex_target = tgt; ex_predTaken = ptk; ex_predTarget = ptgt;
    #1;
    hit  = mHit(mPc);
    pT   = hit && (mCtr[idxOf(mPc)] >= CTHR);
    pTg  = hit ? mTgt[idxOf(mPc)] : mPc + 32'd4;
    mis  = v && (br ? ((tk != ptk) || (tk && tgt != ptgt)) : ptk);
    corr = (br && tk) ? tgt : epc + 32'd4;
    if (mLive) begin
      chk("addrInst", addrInst, mPc);
      chk("if_predTaken", 32'(if_predTaken), 32'(pT));
      chk("if_predTarget", if_predTarget, pTg);
      chk("redirect", 32'(redirect), 32'(mis));
      chk("perf_branches", 32'(perf_branches), 32'(mBr));
      chk("perf_mispredict", 32'(perf_mispredict), 32'(mMis));
    end
    if (r) begin
      mLive = 1'b1;
      mPc = PCI; mBr = 0; mMis = 0;
      for (int k = 0; k < ENT; k++) begin mValid[k] = 1'b0; mCtr[k] = 0; end
    end else begin
      mPc = mis ? corr : s ? mPc : pT ? pTg : mPc + 32'd4;
      if (v && br && mBr < PMAX) mBr++;
      if (mis && mMis < PMAX) mMis++;
      i = idxOf(epc);
      if (v && br) begin
        if (mHit(epc)) begin
          if (tk) begin
            if (mCtr[i] < CMAX) mCtr[i]++;
            mTgt[i] = tgt;
          end else if (mCtr[i] > 0) mCtr[i]--;
        end else if (tk) begin
          mValid[i] = 1'b1; mTag[i] = tagOf(epc); mTgt[i] = tgt; mCtr[i] = CTHR;
        end
      end else if (v && ptk && mHit(epc)) begin
        mValid[i] = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit s);
    cycle(1'b0, s, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Non-branch in EX that was predicted taken: forces a redirect to a.
  task automatic jumpTo(input logic [31:0] a);
    cycle(1'b0, 1'b0, 1'b1, a - 32'd4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
    cycle(1'b0, 1'b0, 1'b1, epc, 1'b1, tk, tgt, ptk, ptgt);
  endtask

  logic [31:0] pcPool [8];
  logic [31:0] tgtPool[6];

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Sequential fetch after reset
    idle(1'b0); chk("seq0", addrInst, 32'h0); chk("seq0_pred", 32'(if_predTaken), 32'h0);
    idle(1'b0); chk("seq1", addrInst, 32'h4);
    idle(1'b0); chk("seq2", addrInst, 32'h8); chk("seq2_redir", 32'(redirect), 32'h0);

    // First taken branch allocates, second visit predicts it
    jumpTo(32'h40);
    resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    chk("br1_pc", addrInst, 32'h40); chk("br1_redir", 32'(redirect), 32'h1);
    idle(1'b0); chk("br1_next", addrInst, 32'h100);
    jumpTo(32'h40);
    idle(1'b0); chk("br2_pred", 32'(if_predTaken), 32'h1); chk("br2_tgt", if_predTarget, 32'h100);
    resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    chk("br2_pc", addrInst, 32'h100); chk("br2_redir", 32'(redirect), 32'h0);

    // Trained branch goes not-taken twice
    resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100); chk("nt1_redir", 32'(redirect), 32'h1);
    idle(1'b0); chk("nt1_next", addrInst, 32'h44);
    jumpTo(32'h40);
    idle(1'b0); chk("nt1_pred", 32'(if_predTaken), 32'h1);
    resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100); chk("nt2_redir", 32'(redirect), 32'h1);
    idle(1'b0);
    jumpTo(32'h40);
    idle(1'b0); chk("nt2_pred", 32'(if_predTaken), 32'h0); chk("nt2_tgt", if_predTarget, 32'h100);
    idle(1'b0); chk("nt2_next", addrInst, 32'h44);

    // Mispredict during stall, then a plain stall
    cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("stl_redir", 32'(redirect), 32'h1);
    for (int k = 0; k < 3; k++) begin idle(1'b1); chk("stl_hold", addrInst, 32'h204); end
    idle(1'b0); chk("stl_rel", addrInst, 32'h204);
    idle(1'b0); chk("stl_adv", addrInst, 32'h208);

    // Aliasing eviction
    resolve(32'h80, 1'b1, 32'h300, 1'b0, 32'h84); chk("al_redir", 32'(redirect), 32'h1);
    idle(1'b0); chk("al_next", addrInst, 32'h300);
    jumpTo(32'h40);
    idle(1'b0); chk("al_pred", 32'(if_predTaken), 32'h0); chk("al_tgt", if_predTarget, 32'h44);
    idle(1'b0); chk("al_seq", addrInst, 32'h44);

    // Reset coinciding with a mispredict
    cycle(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h500, 1'b0, 32'h84);
    chk("rst_redir", 32'(redirect), 32'h1);
    idle(1'b0); chk("rst_pc", addrInst, PCI);
    chk("rst_br", 32'(perf_branches), 32'h0); chk("rst_mis", 32'(perf_mispredict), 32'h0);
    jumpTo(32'h80);
    idle(1'b0); chk("rst_inv", 32'(if_predTaken), 32'h0); chk("rst_tgt", if_predTarget, 32'h84);

    // Random EX traffic
    tgtPool = '{32'h100, 32'h40, 32'h80, 32'h300, 32'hFFFF_FFF8, 32'h0};
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] epc, tgt, ptgt;
      bit          r, s, v, br, tk, ptk;
      pcPool = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h100, 32'hFFFF_FFFC, mPc,
                 $urandom & 32'hFFFF_FFFC};
      tgtPool[5] = $urandom & 32'hFFFF_FFFC;
      r   = ($urandom_range(0, 399) == 0);
      s   = ($urandom_range(0, 4) == 0);
      v   = ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 1) == 1);
      epc = pcPool[$urandom_range(0, 7)];
      tgt = tgtPool[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) begin
        ptk  = mHit(epc) && (mCtr[idxOf(epc)] >= CTHR);
        ptgt = mHit(epc) ? mTgt[idxOf(epc)] : epc + 32'd4;
      end else begin
        ptk  = ($urandom_range(0, 1) == 1);
        ptgt = tgtPool[$urandom_range(0, 5)];
      end
      cycle(r, s, v, epc, br, tk, tgt, ptk, ptgt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
